// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared text-mode timing constants and fill FSM state type
package text_pkg;

   localparam int WORDS_PER_ROW = 40;
   localparam int CHAR_H        = 16;
   localparam int ROWS          = 30;
   localparam int H_ACTIVE      = 640;
   localparam int V_TOTAL       = 525;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fill_state_t;

endpackage

// File: rtl/line_buf_2bank.sv
// rtl/line_buf_2bank.sv - two-bank character-row line buffer, sync write / async read
module line_buf_2bank #(
   parameter int WORDS = 40
) (
   input  logic        clk,
   input  logic        we,
   input  logic        wr_bank,
   input  logic [5:0]  wr_idx,
   input  logic [31:0] wr_data,
   input  logic        rd_bank,
   input  logic [5:0]  rd_idx,
   output logic [31:0] rd_data
);

   logic [31:0] mem [2][WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_bank][wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/text_row_prefetch.sv
// rtl/text_row_prefetch.sv - copies the next character row from VRAM into the idle
// line-buffer bank during hblank so the colour mapper reads with zero latency
module text_row_prefetch
   import text_pkg::*;
#(
   parameter int READ_LAT = 2,
   parameter int ADDR_W   = 11
) (
   input  logic              pixel_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   input  logic [31:0]       bram_dout,
   output logic [31:0]       row_word,
   output logic              row_valid,
   output logic              fill_busy,
   output logic              overrun
);

   fill_state_t state, state_n;

   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] row_ext;
   logic [5:0]        idx;
   logic [5:0]        issued_idx;
   logic              fill_bank;
   logic [1:0]        bank_valid;
   logic [4:0]        target_row;
   logic              trigger;
   logic              frame_end;
   logic              row_end;
   logic              start;
   logic              issue;
   logic              finish;
   logic              upstream_busy;
   logic [31:0]       buf_word;

   logic [READ_LAT-1:0] pipe_v;
   logic [5:0]          pipe_idx [READ_LAT];

   // The displayed bank is DrawY[4]; the target row is always the other parity.
   always_comb begin
      frame_end  = (DrawY == 10'(V_TOTAL - 1));
      row_end    = (DrawY[3:0] == 4'hF) && (DrawY < 10'(ROWS * CHAR_H - 1));
      trigger    = (DrawX == 10'(H_ACTIVE)) && (row_end || frame_end);
      target_row = frame_end ? 5'd0 : DrawY[8:4] + 5'd1;
      row_ext    = ADDR_W'(target_row);
   end

   always_comb begin
      state_n       = state;
      start         = 1'b0;
      issue         = 1'b0;
      finish        = 1'b0;
      upstream_busy = bram_en;
      for (int i = 0; i < READ_LAT - 1; i++) begin
         upstream_busy = upstream_busy | pipe_v[i];
      end
      case (state)
         IDLE: begin
            if (trigger) begin
               start   = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (idx == 6'(WORDS_PER_ROW - 1)) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            // Only the head stage may still hold data; it is written on this same edge.
            if (!upstream_busy) begin
               finish  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         bram_en    <= 1'b0;
         bram_addr  <= '0;
         fill_busy  <= 1'b0;
         overrun    <= 1'b0;
         bank_valid <= 2'b00;
         pipe_v     <= '0;
         base       <= '0;
         idx        <= '0;
         issued_idx <= '0;
         fill_bank  <= 1'b0;
      end else begin
         bram_en <= issue;
         if (issue) begin
            bram_addr  <= base + ADDR_W'(idx);
            issued_idx <= idx;
            idx        <= idx + 6'd1;
         end
         if (start) begin
            base                     <= (row_ext << 5) + (row_ext << 3);
            idx                      <= '0;
            fill_bank                <= target_row[0];
            bank_valid[target_row[0]] <= 1'b0;
            fill_busy                <= 1'b1;
         end
         if (finish) begin
            bank_valid[fill_bank] <= 1'b1;
            fill_busy             <= 1'b0;
         end
         if (trigger && (state != IDLE)) begin
            overrun <= 1'b1;
         end
         pipe_v[0] <= bram_en;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      pipe_idx[0] <= issued_idx;
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_idx[i] <= pipe_idx[i-1];
      end
   end

   line_buf_2bank #(
      .WORDS (WORDS_PER_ROW)
   ) u_line_buf (
      .clk     (pixel_clk),
      .we      (pipe_v[READ_LAT-1]),
      .wr_bank (fill_bank),
      .wr_idx  (pipe_idx[READ_LAT-1]),
      .wr_data (bram_dout),
      .rd_bank (DrawY[4]),
      .rd_idx  (DrawX[9:4]),
      .rd_data (buf_word)
   );

   assign row_word  = (DrawX < 10'(H_ACTIVE)) ? buf_word : 32'h0;
   assign row_valid = bank_valid[DrawY[4]];

endmodule

// File: tb/tb_text_row_prefetch.sv
// tb/tb_text_row_prefetch.sv - scoreboard bench for text_row_prefetch
module tb_text_row_prefetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [10:0] bram_addr;
   logic        bram_en;
   logic [31:0] bram_dout;
   logic [31:0] row_word;
   logic        row_valid;
   logic        fill_busy;
   logic        overrun;

   logic [31:0] data_tag = 32'h0;
   logic [31:0] d1;
   logic [10:0] exp_q [$];
   logic [10:0] mon_exp;
   int          n_vec = 0;
   int          n_err = 0;

   text_row_prefetch dut (
      .pixel_clk (clk),
      .reset     (reset),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .bram_addr (bram_addr),
      .bram_en   (bram_en),
      .bram_dout (bram_dout),
      .row_word  (row_word),
      .row_valid (row_valid),
      .fill_busy (fill_busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // VRAM model: word n holds n (optionally tagged), two-cycle read latency.
   always @(posedge clk) begin
      d1        <= data_tag | 32'(bram_addr);
      bram_dout <= d1;
   end

   always @(negedge clk) begin
      if (bram_en === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_issue: bram_addr=%0d, none expected", bram_addr);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bram_addr !== mon_exp) begin
               n_err++;
               $display("FAIL issue_addr: got %0d expected %0d", bram_addr, mon_exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   task automatic rd_chk(input string name, input int y, input int x,
                         input logic [31:0] exp_word);
      DrawY = 10'(y);
      DrawX = 10'(x);
      #1;
      chk(name, row_word, exp_word);
   endtask

   task automatic push_row(input int row, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(11'(row * 40 + i));
      end
   endtask

   task automatic wait_idle(input string name, input int exp_cycles);
      int cnt;
      cnt = 0;
      while (fill_busy === 1'b1 && cnt < 200) begin
         cnt++;
         tick();
      end
      chk(name, cnt, exp_cycles);
   endtask

   initial begin
      int viol;
      int cnt;
      reset = 1'b1;
      DrawX = 10'd0;
      DrawY = 10'd0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      chk("rst_bram_en", 32'(bram_en), 0);
      chk("rst_bram_addr", 32'(bram_addr), 0);
      chk("rst_fill_busy", 32'(fill_busy), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_row_valid", 32'(row_valid), 0);

      // 1: end of frame fetches row 0 into bank 0
      push_row(0, 40);
      DrawY = 10'd524;
      DrawX = 10'd640;
      tick();
      DrawX = 10'd641;
      wait_idle("t1_busy_len", 43);
      rd_chk("t1_word_x32", 0, 32, 32'd2);
      chk("t1_row_valid", 32'(row_valid), 1);
      DrawY = 10'd16;
      #1;
      chk("t1_bank1_invalid", 32'(row_valid), 0);

      // 2: last line of row 0 fetches row 1 into bank 1
      push_row(1, 40);
      DrawY = 10'd15;
      DrawX = 10'd640;
      tick();
      DrawX = 10'd641;
      wait_idle("t2_busy_len", 43);
      rd_chk("t2_word_x624", 16, 624, 32'd79);
      chk("t2_row_valid", 32'(row_valid), 1);
      rd_chk("t2_bank0_x32", 0, 32, 32'd2);
      rd_chk("t2_bank0_x0", 5, 0, 32'd0);

      // 3: last active line never triggers
      viol = 0;
      DrawY = 10'd479;
      for (int i = 0; i < 800; i++) begin
         DrawX = 10'((i + 640) % 800);
         tick();
         if (fill_busy !== 1'b0 || bram_en !== 1'b0) viol++;
      end
      chk("t3_no_fill", 32'(viol), 0);

      // 6: blanking columns read as zero
      rd_chk("t6_blank_y479", 479, 700, 32'h0);
      rd_chk("t6_blank_y16", 16, 700, 32'h0);

      // 4: trigger held two cycles -> one fill, sticky overrun
      chk("t4_overrun_before", 32'(overrun), 0);
      push_row(2, 40);
      DrawY = 10'd31;
      DrawX = 10'd640;
      tick();
      tick();
      DrawX = 10'd641;
      chk("t4_overrun_set", 32'(overrun), 1);
      wait_idle("t4_busy_rest", 42);
      rd_chk("t4_word_x32", 0, 32, 32'd82);
      chk("t4_row_valid", 32'(row_valid), 1);
      chk("t4_overrun_sticky", 32'(overrun), 1);
      chk("t4_queue_drained", 32'(exp_q.size()), 0);

      // 5: reset mid-fill of row 3 (bank 1) at issue idx 10
      push_row(3, 11);
      data_tag = 32'hA500_0000;
      DrawY = 10'd47;
      DrawX = 10'd640;
      tick();
      DrawX = 10'd641;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!(bram_en === 1'b1 && bram_addr == 11'd130) && cnt < 100);
      chk("t5_reached_idx10", 32'(cnt < 100), 1);
      reset = 1'b1;
      tick();
      chk("t5_bram_en", 32'(bram_en), 0);
      chk("t5_fill_busy", 32'(fill_busy), 0);
      chk("t5_overrun_cleared", 32'(overrun), 0);
      DrawY = 10'd16;
      #1;
      chk("t5_row_valid_b1", 32'(row_valid), 0);
      DrawY = 10'd0;
      #1;
      chk("t5_row_valid_b0", 32'(row_valid), 0);
      reset = 1'b0;
      repeat (6) tick();
      data_tag = 32'h0;
      rd_chk("t5_late_idx10", 16, 160, 32'd50);
      rd_chk("t5_late_idx9", 16, 144, 32'd49);
      rd_chk("t5_untouched_idx20", 16, 320, 32'd60);
      rd_chk("t5_bank0_kept", 0, 32, 32'd82);
      chk("t5_queue_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
